// File: rtl/binary_erode_3x3_pkg.sv
// Shared constants and types for the 3x3 binary erosion stage.
package erode_pkg;
    localparam int unsigned IMG_W = 600;
    localparam int unsigned IMG_H = 480;
    localparam int unsigned COL_W = 10;
    localparam int unsigned ROW_W = 9;

    typedef logic [COL_W-1:0] col_t;
    typedef logic [ROW_W-1:0] row_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;
endpackage

// File: rtl/binary_erode_3x3_if.sv
// Pixel-stream bundle between binarization, erosion and segmentation.
interface binary_erode_3x3_if;
    logic pix_vld;
    logic pix_data;
    logic pix_sof;
    logic out_vld;
    logic out_data;
    logic out_sof;
    logic out_eof;
    logic frame_err;
    logic busy;

    modport master (
        output pix_vld, pix_data, pix_sof,
        input  out_vld, out_data, out_sof, out_eof, frame_err, busy
    );

    modport slave (
        input  pix_vld, pix_data, pix_sof,
        output out_vld, out_data, out_sof, out_eof, frame_err, busy
    );
endinterface

// File: rtl/binary_erode_3x3_fifo_y.sv
// One-line 1-bit circular buffer; q is registered and valid one cycle after rdreq.
module fifo_y
    import erode_pkg::*;
#(
    parameter int unsigned DEPTH = IMG_W
) (
    input  logic clock,
    input  logic reset_n,
    input  logic wrreq,
    input  logic data,
    input  logic rdreq,
    output logic q
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clock) begin
        if (wrreq) mem[wr_ptr] <= data;
    end

    // Same-slot read and write in one cycle returns the old bit (a full line ago).
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            q      <= 1'b0;
        end else begin
            if (wrreq) wr_ptr <= bump(wr_ptr);
            if (rdreq) begin
                q      <= mem[rd_ptr];
                rd_ptr <= bump(rd_ptr);
            end
        end
    end
endmodule

// File: rtl/binary_erode_3x3.sv
// 3x3 binary erosion; each output is the AND of the window ending at the input pixel.
module binary_erode_3x3
    import erode_pkg::*;
#(
    parameter int unsigned FRAME_H = IMG_H
) (
    input logic               clock,
    input logic               reset_n,
    binary_erode_3x3_if.slave bus
);
    state_t     state;
    col_t       col, col_nxt, col_d1;
    row_t       row, row_nxt, row_d1;
    logic       busy_q, frame_err_q;
    logic       at_origin, at_last, sof_err, accept, flush, fifo_rst_n;
    logic       rd_a, rd_b, wr_b, q_a, q_b;
    logic       vld_d1, pix_d1, sof_d1, eof_d1;
    logic [5:0] win;
    logic [2:0] col_vec;
    logic       out_vld_q, out_data_q, out_sof_q, out_eof_q;

    always_comb begin
        at_origin = (col == '0) && (row == '0);
        at_last   = (col == COL_W'(IMG_W - 1)) && (row == ROW_W'(FRAME_H - 1));
        sof_err   = (state == RUN) && bus.pix_vld && bus.pix_sof && !at_origin;
        accept    = bus.pix_vld && (((state == IDLE) && bus.pix_sof) ||
                                    ((state == RUN) && !sof_err));
        flush      = (state == FLUSH);
        fifo_rst_n = reset_n & ~flush;
        rd_a       = accept && (row != '0);
        rd_b       = accept && (row >= ROW_W'(2));
        col_nxt    = col + COL_W'(1);
        row_nxt    = row;
        if (col == COL_W'(IMG_W - 1)) begin
            col_nxt = '0;
            row_nxt = row + ROW_W'(1);
        end
        if (at_last) begin
            col_nxt = '0;
            row_nxt = '0;
        end
        col_vec = {q_b, q_a, pix_d1};
    end

    fifo_y #(.DEPTH(IMG_W)) line_a (
        .clock(clock), .reset_n(fifo_rst_n), .wrreq(accept),
        .data(bus.pix_data), .rdreq(rd_a), .q(q_a)
    );

    fifo_y #(.DEPTH(IMG_W)) line_b (
        .clock(clock), .reset_n(fifo_rst_n), .wrreq(wr_b),
        .data(q_a), .rdreq(rd_b), .q(q_b)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= IDLE;
            col         <= '0;
            row         <= '0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            unique case (state)
                IDLE: if (accept) begin
                    state  <= RUN;
                    busy_q <= 1'b1;
                    col    <= col_nxt;
                    row    <= row_nxt;
                end
                RUN: if (sof_err) begin
                    state       <= FLUSH;
                    frame_err_q <= 1'b1;
                end else if (accept) begin
                    col <= col_nxt;
                    row <= row_nxt;
                    if (at_last) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                FLUSH: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    col    <= '0;
                    row    <= '0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // win[5:3] holds column c-1, win[2:0] column c-2; current column comes from the FIFOs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            vld_d1     <= 1'b0;
            pix_d1     <= 1'b0;
            sof_d1     <= 1'b0;
            eof_d1     <= 1'b0;
            col_d1     <= '0;
            row_d1     <= '0;
            wr_b       <= 1'b0;
            win        <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= 1'b0;
            out_sof_q  <= 1'b0;
            out_eof_q  <= 1'b0;
        end else begin
            vld_d1     <= accept;
            pix_d1     <= bus.pix_data;
            sof_d1     <= accept && (state == IDLE);
            eof_d1     <= accept && at_last;
            col_d1     <= col;
            row_d1     <= row;
            wr_b       <= rd_a;
            out_vld_q  <= vld_d1;
            out_sof_q  <= sof_d1;
            out_eof_q  <= eof_d1;
            out_data_q <= vld_d1 && (row_d1 >= ROW_W'(2)) && (col_d1 >= COL_W'(2)) &&
                          (&{win, col_vec});
            if (flush) begin
                win <= '0;
            end else if (vld_d1) begin
                win <= {col_vec, (col_d1 == '0) ? 3'b000 : win[5:3]};
            end
        end
    end

    assign bus.out_vld   = out_vld_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sof   = out_sof_q;
    assign bus.out_eof   = out_eof_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = busy_q;
endmodule
